// File: rtl/riscv_pipe_pkg.sv
// rtl/riscv_pipe_pkg.sv - shared pipeline types and constants for the writeback stage
package riscv_pipe_pkg;

  // Load funct3 encodings
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // Default number of S_WAIT cycles before a load is abandoned
  localparam int LOAD_TIMEOUT_DEF = 16;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_WAIT = 1'b1
  } wb_state_t;

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - selects and extends load data from a word-aligned read
module load_align
  import riscv_pipe_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  output logic [31:0] data,
  output logic        misalign
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick byte/half by offset, then extend by funct3; misaligned halves/words
  // still take the half selected by off[1] (or the full word).
  always_comb begin
    byte_sel = rdata[7:0];
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    data     = rdata;
    misalign = 1'b0;
    case (off)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    case (funct3)
      LB: data = {{24{byte_sel[7]}}, byte_sel};
      LH: begin
        data     = {{16{half_sel[15]}}, half_sel};
        misalign = off[0];
      end
      LW: misalign = (off != 2'd0);
      LBU: data = {24'd0, byte_sel};
      LHU: begin
        data     = {16'd0, half_sel};
        misalign = off[0];
      end
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - pipeline writeback: load wait/timeout FSM, RF write, perf counters
module wb_stage
  import riscv_pipe_pkg::*;
#(
  parameter int LOAD_TIMEOUT = LOAD_TIMEOUT_DEF,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      wb_result,
  input  logic             wb_mem_write,
  input  logic             wb_alu_to_reg,
  input  logic [4:0]       wb_dest_reg_sel,
  input  logic             wb_branch,
  input  logic             wb_branch_nxt,
  input  logic             wb_mem_to_reg,
  input  logic [1:0]       wb_read_address,
  input  logic [2:0]       mem_alu_operation,
  input  logic [31:0]      dmem_rdata,
  input  logic             dmem_rvalid,
  output logic             stall_read,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic             load_err,
  output logic             misalign_err,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int TMR_W = $clog2(LOAD_TIMEOUT + 1);

  wb_state_t        state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             load_err_q, load_err_d;
  logic             misalign_err_q, misalign_err_d;
  logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic        live;
  logic        is_load;
  logic        retire;
  logic        stall;
  logic [31:0] ld_data;
  logic        ld_misalign;

  // wb_branch is informational here; only the instruction behind it is squashed
  logic unused_branch;
  assign unused_branch = wb_branch;

  load_align u_load_align (
    .rdata    (dmem_rdata),
    .funct3   (mem_alu_operation),
    .off      (wb_read_address),
    .data     (ld_data),
    .misalign (ld_misalign)
  );

  assign live    = (wb_alu_to_reg | wb_mem_write) & ~wb_branch_nxt;
  assign is_load = live & wb_mem_to_reg;

  // Next-state, retire/stall decision and writeback data selection
  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    load_err_d     = load_err_q;
    misalign_err_d = 1'b0;
    retire         = 1'b0;
    stall          = 1'b0;
    rf_wdata       = wb_result;
    case (state_q)
      S_RUN: begin
        if (is_load) begin
          if (dmem_rvalid) begin
            retire         = 1'b1;
            rf_wdata       = ld_data;
            misalign_err_d = ld_misalign;
          end else begin
            stall   = 1'b1;
            state_d = S_WAIT;
            timer_d = TMR_W'(1);
          end
        end else if (live) begin
          retire = 1'b1;
        end
      end
      default: begin
        if (dmem_rvalid) begin
          retire         = 1'b1;
          rf_wdata       = ld_data;
          misalign_err_d = ld_misalign;
          state_d        = S_RUN;
          timer_d        = '0;
        end else if (timer_q == TMR_W'(LOAD_TIMEOUT)) begin
          // Abandon the load: retire it with zero data and flag the error
          retire     = 1'b1;
          rf_wdata   = 32'd0;
          load_err_d = 1'b1;
          state_d    = S_RUN;
          timer_d    = '0;
        end else begin
          stall   = 1'b1;
          timer_d = timer_q + TMR_W'(1);
        end
      end
    endcase
    retired_cnt_d = retired_cnt_q + CNT_W'(retire);
    stall_cnt_d   = stall_cnt_q + CNT_W'(stall);
  end

  assign stall_read = stall & reset_n;
  assign rf_we      = retire & wb_alu_to_reg & (wb_dest_reg_sel != 5'd0) & reset_n;
  assign rf_waddr   = wb_dest_reg_sel;

  // State, timer, sticky error, pulse and counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_RUN;
      timer_q        <= '0;
      load_err_q     <= 1'b0;
      misalign_err_q <= 1'b0;
      retired_cnt_q  <= '0;
      stall_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      load_err_q     <= load_err_d;
      misalign_err_q <= misalign_err_d;
      retired_cnt_q  <= retired_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign load_err     = load_err_q;
  assign misalign_err = misalign_err_q;
  assign retired_cnt  = retired_cnt_q;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed self-checking bench for wb_stage
module tb_wb_stage;
  import riscv_pipe_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [31:0] wb_result;
  logic        wb_mem_write;
  logic        wb_alu_to_reg;
  logic [4:0]  wb_dest_reg_sel;
  logic        wb_branch;
  logic        wb_branch_nxt;
  logic        wb_mem_to_reg;
  logic [1:0]  wb_read_address;
  logic [2:0]  mem_alu_operation;
  logic [31:0] dmem_rdata;
  logic        dmem_rvalid;
  logic        stall_read;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        load_err;
  logic        misalign_err;
  logic [31:0] retired_cnt;
  logic [31:0] stall_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  wb_stage #(.LOAD_TIMEOUT(4), .CNT_W(32)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .wb_result         (wb_result),
    .wb_mem_write      (wb_mem_write),
    .wb_alu_to_reg     (wb_alu_to_reg),
    .wb_dest_reg_sel   (wb_dest_reg_sel),
    .wb_branch         (wb_branch),
    .wb_branch_nxt     (wb_branch_nxt),
    .wb_mem_to_reg     (wb_mem_to_reg),
    .wb_read_address   (wb_read_address),
    .mem_alu_operation (mem_alu_operation),
    .dmem_rdata        (dmem_rdata),
    .dmem_rvalid       (dmem_rvalid),
    .stall_read        (stall_read),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .load_err          (load_err),
    .misalign_err      (misalign_err),
    .retired_cnt       (retired_cnt),
    .stall_cnt         (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic set_bubble();
    wb_result         = 32'd0;
    wb_mem_write      = 1'b0;
    wb_alu_to_reg     = 1'b0;
    wb_dest_reg_sel   = 5'd0;
    wb_branch         = 1'b0;
    wb_branch_nxt     = 1'b0;
    wb_mem_to_reg     = 1'b0;
    wb_read_address   = 2'd0;
    mem_alu_operation = 3'd0;
    dmem_rdata        = 32'd0;
    dmem_rvalid       = 1'b0;
  endtask

  task automatic set_alu(input logic [4:0] rd, input logic [31:0] res);
    set_bubble();
    wb_alu_to_reg   = 1'b1;
    wb_dest_reg_sel = rd;
    wb_result       = res;
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off,
                          input logic rv, input logic [31:0] rdat);
    set_bubble();
    wb_alu_to_reg     = 1'b1;
    wb_mem_to_reg     = 1'b1;
    wb_dest_reg_sel   = rd;
    wb_result         = 32'h1111_1111;
    mem_alu_operation = f3;
    wb_read_address   = off;
    dmem_rvalid       = rv;
    dmem_rdata        = rdat;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    set_bubble();
    tick(); tick(); #1;
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_stall", 32'(stall_read), 32'd0);
    chk("rst_retired", retired_cnt, 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);
    chk("rst_misalign", 32'(misalign_err), 32'd0);

    // ALU writeback, same cycle
    tick(); reset_n = 1'b1; set_alu(5'd5, 32'h1234); #1;
    chk("alu_we", 32'(rf_we), 32'd1);
    chk("alu_waddr", 32'(rf_waddr), 32'd5);
    chk("alu_wdata", rf_wdata, 32'h1234);

    // x0 write dropped but counted
    tick(); set_alu(5'd0, 32'h55); #1;
    chk("alu_retired", retired_cnt, 32'd1);
    chk("x0_we", 32'(rf_we), 32'd0);

    // squashed instruction
    tick(); set_alu(5'd7, 32'h66); wb_branch_nxt = 1'b1; #1;
    chk("x0_retired", retired_cnt, 32'd2);
    chk("squash_we", 32'(rf_we), 32'd0);

    // load formatting with immediate response
    tick(); set_load(5'd1, LB, 2'd3, 1'b1, 32'h80FF_7F01); #1;
    chk("squash_retired", retired_cnt, 32'd2);
    chk("lb_we", 32'(rf_we), 32'd1);
    chk("lb_stall", 32'(stall_read), 32'd0);
    chk("lb_data", rf_wdata, 32'hFFFF_FF80);
    tick(); set_load(5'd2, LBU, 2'd1, 1'b1, 32'h80FF_7F01); #1;
    chk("lbu_data", rf_wdata, 32'h0000_007F);
    chk("lb_misalign", 32'(misalign_err), 32'd0);
    tick(); set_load(5'd3, LH, 2'd2, 1'b1, 32'h80FF_7F01); #1;
    chk("lh_data", rf_wdata, 32'hFFFF_80FF);
    chk("lh_retired", retired_cnt, 32'd4);
    tick(); set_load(5'd4, LHU, 2'd1, 1'b1, 32'h80FF_7F01); #1;
    chk("lhu_mis_data", rf_wdata, 32'h0000_7F01);
    chk("lhu_we", 32'(rf_we), 32'd1);
    // store: counted, no RF write; misalign pulse from the LHU shows now
    tick(); set_bubble(); wb_mem_write = 1'b1; wb_dest_reg_sel = 5'd6; #1;
    chk("lhu_misalign", 32'(misalign_err), 32'd1);
    chk("store_we", 32'(rf_we), 32'd0);
    chk("store_pre_retired", retired_cnt, 32'd6);
    tick(); set_bubble(); #1;
    chk("misalign_pulse_end", 32'(misalign_err), 32'd0);
    chk("store_retired", retired_cnt, 32'd7);

    // load response 3 cycles late
    tick(); set_load(5'd9, LW, 2'd0, 1'b0, 32'h0); #1;
    chk("wait_stall0", 32'(stall_read), 32'd1);
    chk("wait_we0", 32'(rf_we), 32'd0);
    for (int i = 1; i < 3; i++) begin
      tick(); #1;
      chk("wait_stall", 32'(stall_read), 32'd1);
    end
    tick(); dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_BABE; #1;
    chk("wait_done_stall", 32'(stall_read), 32'd0);
    chk("wait_we", 32'(rf_we), 32'd1);
    chk("wait_waddr", 32'(rf_waddr), 32'd9);
    chk("wait_wdata", rf_wdata, 32'hCAFE_BABE);
    tick(); set_alu(5'd3, 32'h77); #1;
    chk("nobubble_we", 32'(rf_we), 32'd1);
    chk("nobubble_stall", 32'(stall_read), 32'd0);
    chk("wait_stall_cnt", stall_cnt, 32'd3);
    chk("wait_retired", retired_cnt, 32'd8);

    // timeout
    tick(); set_load(5'd10, LW, 2'd0, 1'b0, 32'hDEAD_BEEF); #1;
    chk("to_stall0", 32'(stall_read), 32'd1);
    chk("to_pre_retired", retired_cnt, 32'd9);
    for (int i = 1; i < 4; i++) begin
      tick(); #1;
      chk("to_stall", 32'(stall_read), 32'd1);
    end
    tick(); #1;
    chk("to_end_stall", 32'(stall_read), 32'd0);
    chk("to_we", 32'(rf_we), 32'd1);
    chk("to_wdata", rf_wdata, 32'd0);
    chk("to_err_pre", 32'(load_err), 32'd0);
    tick(); set_bubble(); #1;
    chk("to_err", 32'(load_err), 32'd1);
    chk("to_stall_cnt", stall_cnt, 32'd7);
    chk("to_retired", retired_cnt, 32'd10);
    tick(); set_alu(5'd4, 32'h9); tick(); #1;
    chk("to_err_sticky", 32'(load_err), 32'd1);

    // async reset in S_WAIT cycle 2
    tick(); set_load(5'd11, LB, 2'd0, 1'b0, 32'h0); #1;
    chk("rw_stall0", 32'(stall_read), 32'd1);
    tick(); #1;
    chk("rw_stall1", 32'(stall_read), 32'd1);
    tick(); #1;
    chk("rw_stall2", 32'(stall_read), 32'd1);
    reset_n = 1'b0; #1;
    chk("rw_rst_stall", 32'(stall_read), 32'd0);
    chk("rw_rst_we", 32'(rf_we), 32'd0);
    chk("rw_rst_retired", retired_cnt, 32'd0);
    chk("rw_rst_stall_cnt", stall_cnt, 32'd0);
    chk("rw_rst_load_err", 32'(load_err), 32'd0);
    tick(); reset_n = 1'b1; set_bubble();
    tick(); set_load(5'd12, LBU, 2'd2, 1'b0, 32'h80FF_7F01); #1;
    chk("rw_again_stall", 32'(stall_read), 32'd1);
    tick(); dmem_rvalid = 1'b1; #1;
    chk("rw_again_stall_off", 32'(stall_read), 32'd0);
    chk("rw_again_we", 32'(rf_we), 32'd1);
    chk("rw_again_wdata", rf_wdata, 32'h0000_00FF);
    tick(); set_bubble(); #1;
    chk("rw_again_stall_cnt", stall_cnt, 32'd1);
    chk("rw_again_retired", retired_cnt, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
